uart_rx_buffer: RTL

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_rx_buffer.sv
// Purpose : captures one frame per rising edge of uart_rx_done into a first-word-fall-through FIFO,
//           counts data/frame errors (saturating) and flags frames lost to a full FIFO (sticky overflow).
// Latency : a captured frame is written on the capture edge and shows on rd_valid/rd_data one cycle later.
// Backpr. : the consumer stalls with rd_ready=0. The receiver cannot be stalled, so a capture into a full
//           FIFO (with no pop in the same cycle) is discarded and overflow is set.
// Ports   : sys_clk/reset (async, active-low) | uart_rx_dout, uart_rx_done, uart_rx_data_error,
//           uart_rx_frame_error from the receiver | drop_err, clr_status control | rd_valid/rd_ready/
//           rd_data read side | level, full, empty, overflow, data_err_cnt, frame_err_cnt status.
module uart_rx_buffer #(
  parameter int FRAME_WIDTH   = 10,
  parameter int DEPTH         = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic [FRAME_WIDTH-1:0]   uart_rx_dout,
  input  logic                     uart_rx_done,
  input  logic                     uart_rx_data_error,
  input  logic                     uart_rx_frame_error,
  input  logic                     drop_err,
  input  logic                     clr_status,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [FRAME_WIDTH-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [ERR_CNT_WIDTH-1:0] data_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] frame_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Previous-cycle copy of uart_rx_done; resets to 1 so a done already high
  // when reset is released is not mistaken for a new frame.
  logic                     done_q;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic [ERR_CNT_WIDTH-1:0] data_err_cnt_q, data_err_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] frame_err_cnt_q, frame_err_cnt_d;
  logic [FRAME_WIDTH-1:0]   mem_q [DEPTH];

  logic capture, has_err, accept, push, pop, full_w, lost;

  assign full_w  = (level_q == FULL_LVL);
  assign capture = uart_rx_done & ~done_q;
  assign has_err = uart_rx_data_error | uart_rx_frame_error;
  assign accept  = capture & ~(drop_err & has_err);
  assign pop     = rd_valid & rd_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still take a write.
  assign push    = accept & (~full_w | pop);
  assign lost    = accept & full_w & ~pop;

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    overflow_d      = overflow_q;
    data_err_cnt_d  = data_err_cnt_q;
    frame_err_cnt_d = frame_err_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Error counting does not depend on whether the frame is kept.
    if (capture && uart_rx_data_error && (data_err_cnt_q != '1))
      data_err_cnt_d = data_err_cnt_q + ERR_CNT_WIDTH'(1);
    if (capture && uart_rx_frame_error && (frame_err_cnt_q != '1))
      frame_err_cnt_d = frame_err_cnt_q + ERR_CNT_WIDTH'(1);
    if (lost) overflow_d = 1'b1;

    // Clear takes priority over any same-cycle increment or overflow.
    if (clr_status) begin
      overflow_d      = 1'b0;
      data_err_cnt_d  = '0;
      frame_err_cnt_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      done_q          <= 1'b1;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      overflow_q      <= 1'b0;
      data_err_cnt_q  <= '0;
      frame_err_cnt_q <= '0;
    end else begin
      done_q          <= uart_rx_done;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      overflow_q      <= overflow_d;
      data_err_cnt_q  <= data_err_cnt_d;
      frame_err_cnt_q <= frame_err_cnt_d;
    end
  end

  // Storage is not reset; an empty level masks whatever it holds.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_rx_dout;
  end

  assign rd_valid      = (level_q != '0);
  assign rd_data       = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level         = level_q;
  assign full          = full_w;
  assign empty         = ~rd_valid;
  assign overflow      = overflow_q;
  assign data_err_cnt  = data_err_cnt_q;
  assign frame_err_cnt = frame_err_cnt_q;

endmodule
